// File: rtl/inst_rom_pkg.sv
// Shared constants and loader state encoding for the instruction ROM.
package inst_rom_pkg;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;  // fetch answer when not serving: a NOP
  localparam logic        RST_ENABLE = 1'b0;           // reset is active low

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/inst_rom_if.sv
// Fetch port plus boot-loader byte stream of the instruction ROM.
interface inst_rom_if #(parameter int WORD_AW = 10);

  logic               rom_ce_i;
  logic [31:0]        rom_addr_i;
  logic [31:0]        rom_data_o;
  logic               ld_start_i;
  logic [WORD_AW:0]   ld_len_i;
  logic               ld_valid_i;
  logic [7:0]         ld_byte_i;
  logic               ld_ready_o;
  logic               ld_busy_o;
  logic               ld_done_o;
  logic               cpu_hold_o;

  // core / loader side
  modport master (
    output rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_byte_i,
    input  rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, cpu_hold_o
  );

  // ROM side
  modport slave (
    input  rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_byte_i,
    output rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, cpu_hold_o
  );

endinterface

// File: rtl/inst_rom.sv
// Instruction memory: zero-wait combinational fetch, plus a byte-stream boot
// loader that packs MSB-first bytes into words and holds the core while busy.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int WORD_AW = 10
) (
  input  logic         clk,
  input  logic         rst,
  inst_rom_if.slave    bus
);

  localparam int               DEPTH   = 1 << WORD_AW;
  localparam logic [WORD_AW:0] MAX_LEN = (WORD_AW + 1)'(DEPTH);

  logic [31:0]        mem [DEPTH];
  ld_state_e          state, state_nxt;
  logic [WORD_AW:0]   len;
  logic [WORD_AW-1:0] wptr;
  logic [1:0]         bcnt;
  logic [31:0]        wbuf;
  logic               byte_acc;
  logic               start_acc;
  logic [WORD_AW:0]   len_clamped;
  logic [WORD_AW-1:0] idx;
  logic               hit;
  logic               unused_addr_lsb;

  assign byte_acc    = (state == LD_LOAD) && bus.ld_valid_i;
  assign start_acc   = (state == LD_IDLE) && bus.ld_start_i;
  // clamping keeps wptr from wrapping within one load
  assign len_clamped = (bus.ld_len_i > MAX_LEN) ? MAX_LEN : bus.ld_len_i;

  // state register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= LD_IDLE;
    else                   state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:  if (bus.ld_start_i) state_nxt = (bus.ld_len_i == '0) ? LD_DONE : LD_LOAD;
      LD_LOAD:  if (byte_acc && bcnt == 2'd3) state_nxt = LD_WRITE;
      LD_WRITE: state_nxt = (len == (WORD_AW + 1)'(1)) ? LD_DONE : LD_LOAD;
      LD_DONE:  state_nxt = LD_IDLE;
      default:  state_nxt = LD_IDLE;
    endcase
  end

  // loader datapath: length, write pointer, byte counter and word packer
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      len  <= '0;
      wptr <= '0;
      bcnt <= '0;
      wbuf <= '0;
    end else begin
      if (start_acc) begin
        len  <= len_clamped;
        wptr <= '0;
        bcnt <= '0;
      end
      // bcnt wraps 3 -> 0 on the 4th byte, ready for the next word
      if (byte_acc) begin
        wbuf <= {wbuf[23:0], bus.ld_byte_i};
        bcnt <= bcnt + 2'd1;
      end
      if (state == LD_WRITE) begin
        wptr <= wptr + 1'b1;
        len  <= len - 1'b1;
      end
    end
  end

  // memory write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (state == LD_WRITE) mem[wptr] <= wbuf;
  end

  // combinational fetch; only served while idle and inside the array
  assign idx             = bus.rom_addr_i[WORD_AW+1:2];
  assign hit             = bus.rom_ce_i && (state == LD_IDLE) &&
                           (bus.rom_addr_i[31:WORD_AW+2] == '0);
  assign bus.rom_data_o  = hit ? mem[idx] : ZERO_WORD;
  assign unused_addr_lsb = ^bus.rom_addr_i[1:0];

  assign bus.ld_ready_o = (state == LD_LOAD);
  assign bus.ld_busy_o  = (state == LD_LOAD) || (state == LD_WRITE);
  assign bus.ld_done_o  = (state == LD_DONE);
  assign bus.cpu_hold_o = (state != LD_IDLE);

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: stimulus queues expected fetch words and
// done-pulse cycles; a negedge monitor pops and compares them.
module tb_inst_rom;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_rom_if #(.WORD_AW(AW)) bus();
  inst_rom #(.WORD_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic [31:0] exp;
  } fexp_t;

  fexp_t fq[$];
  int    dq[$];
  logic  smp = 1'b0;
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // monitor: fetch samples and done pulses
  always @(negedge clk) begin
    fexp_t e;
    int    d;
    if (smp) begin
      if (fq.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL fetch_queue: got empty expected entry");
      end else begin
        e = fq.pop_front();
        check(e.name, bus.rom_data_o, e.exp);
      end
    end
    if (bus.ld_done_o) begin
      if (dq.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        d = dq.pop_front();
        if (d >= 0) check("done_cycle", cyc, d);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load(input logic [AW:0] len, output int s);
    bus.ld_start_i = 1'b1;
    bus.ld_len_i   = len;
    tick();
    bus.ld_start_i = 1'b0;
    s = cyc;
  endtask

  // present n bytes of w (MSB first), holding each until accepted
  task automatic send_bytes(input logic [31:0] w, input int n, input bit gap);
    bit rdy, ok;
    for (int b = 0; b < n; b++) begin
      ok = 1'b0;
      bus.ld_valid_i = 1'b1;
      bus.ld_byte_i  = w[31-8*b -: 8];
      for (int t = 0; t < 20 && !ok; t++) begin
        rdy = bus.ld_ready_o;
        tick();
        ok = rdy;
      end
      if (!ok) begin
        n_chk++; n_err++;
        $display("FAIL byte_accept: got no ready in 20 cycles expected accept");
      end
      bus.ld_valid_i = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (bus.ld_done_o) begin seen = 1'b1; break; end
      tick();
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a, input bit ce, input logic [31:0] exp, input string name);
    bus.rom_ce_i   = ce;
    bus.rom_addr_i = a;
    fq.push_back('{name: name, exp: exp});
    smp = 1'b1;
    @(negedge clk); #1;
    smp = 1'b0;
    bus.rom_ce_i = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_ready"}, {31'd0, bus.ld_ready_o}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.ld_busy_o},  32'd0);
    check({tag, "_done"},  {31'd0, bus.ld_done_o},  32'd0);
    check({tag, "_hold"},  {31'd0, bus.cpu_hold_o}, 32'd0);
  endtask

  localparam logic [31:0] W0 = 32'h3C01_8000;
  localparam logic [31:0] W1 = 32'h3421_00FF;
  localparam logic [31:0] W2 = 32'hAC22_0004;

  initial begin
    int s;
    bus.rom_ce_i = 1'b0; bus.rom_addr_i = '0;
    bus.ld_start_i = 1'b0; bus.ld_len_i = '0;
    bus.ld_valid_i = 1'b0; bus.ld_byte_i = '0;

    // reset
    rst = 1'b0;
    repeat (3) tick();
    check_idle_outs("reset");
    rst = 1'b1;
    tick();

    // 1: single word, back-to-back bytes
    start_load(11'd1, s);
    dq.push_back(s + 5);
    check("t1_hold_after_start", {31'd0, bus.cpu_hold_o}, 32'd1);
    send_bytes(32'h2402_0005, 4, 1'b0);
    wait_done("t1_done_seen", 10);
    tick();
    check("t1_hold_idle", {31'd0, bus.cpu_hold_o}, 32'd0);
    fetch(32'h0, 1'b1, 32'h2402_0005, "t1_fetch0");

    // 2: three words, gapped valid
    dq.push_back(-1);
    start_load(11'd3, s);
    check("t2_busy", {31'd0, bus.ld_busy_o}, 32'd1);
    check("t2_hold", {31'd0, bus.cpu_hold_o}, 32'd1);
    send_bytes(W0, 4, 1'b1);
    send_bytes(W1, 4, 1'b1);
    send_bytes(W2, 4, 1'b1);
    wait_done("t2_done_seen", 10);
    check("t2_hold_in_done", {31'd0, bus.cpu_hold_o}, 32'd1);
    tick();
    check("t2_hold_after", {31'd0, bus.cpu_hold_o}, 32'd0);
    fetch(32'h0, 1'b1, W0, "t2_fetch0");
    fetch(32'h4, 1'b1, W1, "t2_fetch4");
    fetch(32'h7, 1'b1, W1, "t2_fetch7");
    fetch(32'h8, 1'b1, W2, "t2_fetch8");

    // 3: zero-length load
    start_load(11'd0, s);
    dq.push_back(s);
    check("t3_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    check("t3_done",  {31'd0, bus.ld_done_o},  32'd1);
    tick();
    check("t3_ready_after", {31'd0, bus.ld_ready_o}, 32'd0);
    check("t3_hold_after",  {31'd0, bus.cpu_hold_o}, 32'd0);
    fetch(32'h0, 1'b1, W0, "t3_fetch0");
    fetch(32'h4, 1'b1, W1, "t3_fetch4");

    // 4: reset mid-load, then restart at word 0
    start_load(11'd2, s);
    send_bytes(32'h1122_3344, 4, 1'b0);
    send_bytes(32'h5566_7788, 2, 1'b0);
    rst = 1'b0;
    tick();
    check_idle_outs("t4_rst");
    rst = 1'b1;
    tick();
    fetch(32'h0, 1'b1, 32'h1122_3344, "t4_word0_kept");
    fetch(32'h4, 1'b1, W1, "t4_word1_unchanged");
    start_load(11'd1, s);
    dq.push_back(s + 5);
    send_bytes(32'hDEAD_BEEF, 4, 1'b0);
    fetch(32'h0, 1'b1, 32'h0, "fetch_in_write");
    wait_done("t4_done_seen", 10);
    tick();
    fetch(32'h0, 1'b1, 32'hDEAD_BEEF, "t4_restart0");
    fetch(32'h4, 1'b1, W1, "t4_word1_after");
    fetch(32'h8, 1'b1, W2, "t4_word2_after");

    // 5: disabled and out-of-range fetches
    fetch(32'h0,         1'b0, 32'h0, "t5_ce_off");
    fetch(32'h0000_1000, 1'b1, 32'h0, "t5_out_of_range");
    fetch(32'h8000_0000, 1'b1, 32'h0, "t5_high_addr");

    // 6: oversize length clamps to the full array; mid-load start ignored
    start_load(11'd1029, s);
    dq.push_back(s + 5 * 1024);
    for (int i = 0; i < 1024; i++) begin
      if (i == 500) begin bus.ld_start_i = 1'b1; bus.ld_len_i = 11'd1; end
      send_bytes(32'hC0DE_0000 | i, 4, 1'b0);
      if (i == 500) bus.ld_start_i = 1'b0;
    end
    wait_done("t6_done_seen", 20);
    tick();
    fetch(32'h0,   1'b1, 32'hC0DE_0000, "t6_fetch_first");
    fetch(32'h7FC, 1'b1, 32'hC0DE_01FF, "t6_fetch_mid");
    fetch(32'hFFC, 1'b1, 32'hC0DE_03FF, "t6_fetch_last");
    fetch(32'hFFF, 1'b1, 32'hC0DE_03FF, "t6_fetch_last_lsb");
    fetch(32'h1000, 1'b1, 32'h0,        "t6_fetch_beyond");

    repeat (3) tick();
    if (dq.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL done_pending: got %0d unseen pulses expected 0", dq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
